// File: rtl/twos_accumulator.sv
// twos_accumulator
// Purpose: sums a block of NUM_SAMPLES signed words from the two's-complement
//          converter into a saturating signed accumulator. The block total is
//          presented with a valid/ready handshake, and a sticky flag reports
//          whether saturation occurred.
// Ports:
//   t_clk      in   1       clock, rising edge
//   rst        in   1       synchronous active-high reset
//   start      in   1       begin a block (sampled only in IDLE)
//   in_valid   in   1       in_data valid
//   in_data    in   DATA_W  signed sample
//   in_ready   out  1       sample accepted this cycle (ACCUM)
//   sum_ready  in   1       consumer accepts sum_out
//   sum_valid  out  1       sum_out holds a completed block total
//   sum_out    out  ACC_W   saturated signed block total
//   ovf        out  1       saturation seen in current/presented block
//   busy       out  1       block in progress (state != IDLE)
module twos_accumulator #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned NUM_SAMPLES = 8
) (
  input  logic              t_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              sum_ready,
  output logic              sum_valid,
  output logic [ACC_W-1:0]  sum_out,
  output logic              ovf,
  output logic              busy
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned EXT_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               r_in_ready;
  logic               r_sum_valid;
  logic [ACC_W-1:0]   r_sum_out;
  logic               r_busy;
  logic [EXT_W-1:0]   w_sum;
  logic               w_xfer;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Transfer only while accumulating; in_ready is high exactly in ACCUM.
  assign w_xfer = (r_state == ACCUM) && in_valid;

  // One-bit-wider signed sum; the top two bits disagreeing means out of range.
  assign w_sum = {r_acc[ACC_W-1], r_acc}
               + {{(EXT_W-DATA_W){in_data[DATA_W-1]}}, in_data};

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ACCUM;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      ACCUM: begin
        if (w_xfer) begin
          if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
            w_acc_nxt = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
            w_ovf_nxt = 1'b1;
          end else begin
            w_acc_nxt = w_sum[ACC_W-1:0];
          end
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(NUM_SAMPLES - 1)) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (sum_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs derived from the next state
  always_ff @(posedge t_clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_sum_valid <= 1'b0;
      r_sum_out   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_in_ready  <= (w_state_nxt == ACCUM);
      r_sum_valid <= (w_state_nxt == DONE);
      r_sum_out   <= (w_state_nxt == DONE) ? w_acc_nxt : '0;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign sum_valid = r_sum_valid;
  assign sum_out   = r_sum_out;
  assign ovf       = r_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_twos_accumulator.sv
// tb_twos_accumulator
// Purpose: randomized self-checking bench for twos_accumulator. Two instances
//          (16-bit and 13-bit accumulators) share one stimulus stream and are
//          compared against a saturating-sum reference model.
module tb_twos_accumulator;

  logic        t_clk = 1'b0;
  logic        rst, start, in_valid, sum_ready;
  logic [11:0] in_data;

  logic        a_in_ready, a_sum_valid, a_ovf, a_busy;
  logic [15:0] a_sum_out;
  logic        b_in_ready, b_sum_valid, b_ovf, b_busy;
  logic [12:0] b_sum_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 t_clk = ~t_clk;

  twos_accumulator #(.DATA_W(12), .ACC_W(16), .NUM_SAMPLES(8)) u_dut_a (
    .t_clk(t_clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(a_in_ready), .sum_ready(sum_ready),
    .sum_valid(a_sum_valid), .sum_out(a_sum_out), .ovf(a_ovf), .busy(a_busy)
  );

  twos_accumulator #(.DATA_W(12), .ACC_W(13), .NUM_SAMPLES(8)) u_dut_b (
    .t_clk(t_clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(b_in_ready), .sum_ready(sum_ready),
    .sum_valid(b_sum_valid), .sum_out(b_sum_out), .ovf(b_ovf), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  // Reference: plain integer sum, clamped after every sample.
  function automatic void model(input logic [11:0] s[8], input int accw,
                                output logic [31:0] sum_bits, output logic ov);
    longint acc, hi, lo, v;
    acc = 0;
    hi  = (64'sd1 <<< (accw - 1)) - 1;
    lo  = -(64'sd1 <<< (accw - 1));
    ov  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v   = longint'($signed(s[i]));
      acc = acc + v;
      if (acc > hi) begin
        acc = hi;
        ov  = 1'b1;
      end else if (acc < lo) begin
        acc = lo;
        ov  = 1'b1;
      end
    end
    sum_bits = 32'(acc) & ((32'd1 << accw) - 32'd1);
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_a_ready"}, 32'(a_in_ready),  32'd0);
    check({tag, "_a_valid"}, 32'(a_sum_valid), 32'd0);
    check({tag, "_a_sum"},   32'(a_sum_out),   32'd0);
    check({tag, "_a_ovf"},   32'(a_ovf),       32'd0);
    check({tag, "_a_busy"},  32'(a_busy),      32'd0);
    check({tag, "_b_valid"}, 32'(b_sum_valid), 32'd0);
    check({tag, "_b_sum"},   32'(b_sum_out),   32'd0);
    check({tag, "_b_ovf"},   32'(b_ovf),       32'd0);
    check({tag, "_b_busy"},  32'(b_busy),      32'd0);
  endtask

  // One block: optional start pulse, 8 transfers with random gaps, a DONE
  // stall of 'stall' cycles, then release (optionally with start for b2b).
  task automatic run_block(input logic [11:0] s[8], input int gap_pct,
                           input int stall, input bit do_start, input bit b2b);
    logic [31:0] ea, eb;
    logic        oa, ob;
    int          idx, budget;
    model(s, 16, ea, oa);
    model(s, 13, eb, ob);
    idx = 0;
    budget = 0;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("accum_ready", 32'(a_in_ready), 32'd1);
    check("accum_busy",  32'(b_busy),     32'd1);
    while (idx < 8 && budget < 400) begin
      if (32'($urandom_range(99)) < 32'(gap_pct)) begin
        in_valid = 1'b0;
        in_data  = 12'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = s[idx];
      end
      start = 1'($urandom);
      tick();
      start = 1'b0;
      if (in_valid) idx++;
      budget++;
      if (idx < 8) check("no_early_valid", 32'(a_sum_valid | b_sum_valid), 32'd0);
    end
    in_valid = 1'b0;
    check("xfer_done",   32'(idx),         32'd8);
    check("a_valid",     32'(a_sum_valid), 32'd1);
    check("b_valid",     32'(b_sum_valid), 32'd1);
    check("a_sum",       32'(a_sum_out),   ea);
    check("b_sum",       32'(b_sum_out),   eb);
    check("a_ovf",       32'(a_ovf),       32'(oa));
    check("b_ovf",       32'(b_ovf),       32'(ob));
    check("done_ready",  32'(a_in_ready),  32'd0);
    sum_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'($urandom);
      in_data  = 12'($urandom);
      start    = 1'($urandom);
      tick();
      check("stall_valid", 32'(a_sum_valid), 32'd1);
      check("stall_sum_a", 32'(a_sum_out),   ea);
      check("stall_sum_b", 32'(b_sum_out),   eb);
      check("stall_ready", 32'(b_in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    start     = b2b;
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    check("release_valid", 32'(a_sum_valid), 32'd0);
    check("release_busy",  32'(a_busy),      32'd0);
    check("ovf_hold_b",    32'(b_ovf),       32'(ob));
    if (b2b) begin
      tick();
      start = 1'b0;
    end else begin
      start = 1'b0;
    end
  endtask

  logic [11:0] blk[8];

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; sum_ready = 1'b0; in_data = '0;

    // Reset with random inputs and start held high
    for (int c = 0; c < 2; c++) begin
      start     = 1'b1;
      in_valid  = 1'($urandom);
      in_data   = 12'($urandom);
      sum_ready = 1'($urandom);
      tick();
      check_idle_zero("reset");
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; sum_ready = 1'b0;
    tick();
    check_idle_zero("idle");

    foreach (blk[i]) blk[i] = 12'h001;
    run_block(blk, 0, 3, 1'b1, 1'b0);
    foreach (blk[i]) blk[i] = 12'h800;
    run_block(blk, 0, 1, 1'b1, 1'b0);
    foreach (blk[i]) blk[i] = 12'h7FF;
    run_block(blk, 0, 1, 1'b1, 1'b0);
    foreach (blk[i]) blk[i] = 12'h000;
    run_block(blk, 0, 1, 1'b1, 1'b0);

    // Handshake stress
    foreach (blk[i]) blk[i] = 12'($urandom);
    run_block(blk, 40, 5, 1'b1, 1'b0);

    // Mid-block reset after 3 words
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 12'h7FF;
      tick();
      check("mid_no_valid", 32'(a_sum_valid), 32'd0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("mid_rst");
    tick();
    check("post_rst_valid", 32'(a_sum_valid), 32'd0);
    foreach (blk[i]) blk[i] = 12'h002;
    run_block(blk, 20, 2, 1'b1, 1'b0);

    // Back-to-back blocks
    foreach (blk[i]) blk[i] = 12'($urandom);
    run_block(blk, 10, 0, 1'b1, 1'b1);
    foreach (blk[i]) blk[i] = 12'($urandom);
    run_block(blk, 10, 2, 1'b0, 1'b0);

    // Random blocks biased to extremes to hit saturation both ways
    for (int r = 0; r < 12; r++) begin
      foreach (blk[i]) begin
        case ($urandom_range(3))
          0:       blk[i] = 12'h7FF;
          1:       blk[i] = 12'h800;
          default: blk[i] = 12'($urandom);
        endcase
      end
      run_block(blk, 30, int'($urandom_range(4)), 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
